// File: rtl/xmas_pkg.sv
// Shared definitions for the xmas token source: FSM states, default widths
// and the Galois LFSR polynomial used by the XMAS_SRC_LFSR_EN payload build.
package xmas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } xmas_state_t;

    localparam int XMAS_DATA_W = 32;
    localparam int XMAS_CNT_W  = 16;

    localparam logic [31:0] XMAS_LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out decides whether taps are applied.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? XMAS_LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/xmas_payload_gen.sv
// Payload sequence generator: incrementing counter by default, or a 32-bit
// Galois LFSR when XMAS_SRC_LFSR_EN is defined. value is a registered output.
module xmas_payload_gen
    import xmas_pkg::*;
#(
    parameter int DATA_W = XMAS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

`ifdef XMAS_SRC_LFSR_EN
    logic [31:0] lfsr_q;
    logic [31:0] seed32;

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    always_comb begin
        seed32 = 32'(seed);
        if (seed32 == 32'h0) begin
            seed32 = 32'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 32'h0;
        end else if (load) begin
            lfsr_q <= seed32;
        end else if (advance) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value = DATA_W'(lfsr_q);
`else
    logic [DATA_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= seed;
        end else if (advance) begin
            count_q <= count_q + DATA_W'(1);
        end
    end

    assign value = count_q;
`endif

endmodule

// File: rtl/xmas_source.sv
// Burst token source on an xMAS irdy/trdy channel; payload mode selected by
// XMAS_SRC_LFSR_EN (undefined: incrementing counter, defined: Galois LFSR).
//
// Handshake: a token moves on a rising clk edge where o_irdy=1 and o_trdy=1.
// Once o_irdy is raised it stays high with o_data frozen until that transfer;
// o_irdy and o_data come straight from flops, never from o_trdy.
module xmas_source
    import xmas_pkg::*;
#(
    parameter int DATA_W = XMAS_DATA_W,
    parameter int CNT_W  = XMAS_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [3:0]        gap,
    input  logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] o_data,
    output logic              o_irdy,
    input  logic              o_trdy,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count
);

    xmas_state_t      state;
    xmas_state_t      state_next;
    logic             irdy_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] sent_count_q;
    logic [CNT_W-1:0] sent_inc;
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt;
    logic             accept;
    logic             xfer;
    logic             last_xfer;

    assign accept    = (state == ST_IDLE) && start;
    assign xfer      = (state == ST_SEND) && o_trdy;
    assign sent_inc  = sent_count_q + CNT_W'(1);
    assign last_xfer = xfer && (sent_inc == len_q);

    // State register; irdy is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            irdy_q <= 1'b0;
        end else begin
            state  <= state_next;
            irdy_q <= (state_next == ST_SEND);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (burst_len == '0) ? ST_FIN : ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_xfer) begin
                    state_next = ST_FIN;
                end else if (xfer && (gap_q != 4'd0)) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = ST_SEND;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_irdy     = irdy_q;
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN);
        sent_count = sent_count_q;
    end

    // gap_cnt is loaded with gap-1 so the GAP state lasts exactly gap cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            gap_q        <= 4'd0;
            gap_cnt      <= 4'd0;
            sent_count_q <= '0;
        end else begin
            if (accept) begin
                len_q        <= burst_len;
                gap_q        <= gap;
                sent_count_q <= '0;
            end else if (xfer) begin
                sent_count_q <= sent_inc;
            end

            if (xfer && !last_xfer && (gap_q != 4'd0)) begin
                gap_cnt <= gap_q - 4'd1;
            end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    xmas_payload_gen #(
        .DATA_W (DATA_W)
    ) u_payload_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .seed    (base),
        .advance (xfer),
        .value   (o_data)
    );

endmodule

// File: tb/tb_xmas_source.sv
// Directed bench for xmas_source: table of bursts plus a hand-written
// mid-burst reset sequence, with a payload scoreboard queue.
module tb_xmas_source;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  burst_len;
    logic [3:0]        gap;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] o_data;
    logic              o_irdy;
    logic              o_trdy;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [CNT_W-1:0]  len;
        logic [3:0]        gap;
        logic [DATA_W-1:0] base;
        int                stall;
        bit                rnd;
        int                exp_count;
        logic [DATA_W-1:0] exp_last;
    } burst_vec_t;

    burst_vec_t vecs[8];

    xmas_source #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .gap        (gap),
        .base       (base),
        .o_data     (o_data),
        .o_irdy     (o_irdy),
        .o_trdy     (o_trdy),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] b, input int k);
        logic [31:0] v;
`ifdef XMAS_SRC_LFSR_EN
        v = (b == '0) ? 32'h1 : b;
        for (int i = 0; i < k; i++) begin
            v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        end
`else
        v = b + 32'(k);
`endif
        return v;
    endfunction

    // driver + monitor for one burst
    task automatic run_burst(input burst_vec_t v);
        int                cyc        = 0;
        int                ntok       = 0;
        int                last_x     = 0;
        int                idle       = 0;
        int                stall_left = v.stall;
        bit                stalled    = 0;
        bit                prev_irdy  = 0;
        bit                seen_done  = 0;
        logic [DATA_W-1:0] held       = '0;
        logic [DATA_W-1:0] last_data  = '0;
        logic [DATA_W-1:0] e;

        exp_q.delete();
        for (int k = 0; k < v.exp_count; k++) exp_q.push_back(model(v.base, k));

        @(negedge clk);
        start     = 1'b1;
        burst_len = v.len;
        gap       = v.gap;
        base      = v.base;
        o_trdy    = 1'b1;

        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_irdy_latency", o_irdy, (v.len != 0));
                check("busy_after_start", busy, 1);
            end
            if (stalled) begin
                check("stall_irdy_held", o_irdy, 1);
                check("stall_data_stable", o_data, held);
            end
            stalled = 0;
            if (done) begin
                seen_done = 1;
                start     = 1'b0;
                check("done_latency", cyc - last_x, 1);
                check("done_irdy_low", o_irdy, 0);
            end else begin
                // junk on the config inputs and start must not disturb the burst
                start     = 1'(($urandom_range(0, 1)));
                burst_len = CNT_W'($urandom);
                gap       = 4'($urandom);
                base      = $urandom;
                if (o_irdy) begin
                    if (!prev_irdy && ntok > 0) check("gap_idle_cycles", idle, v.gap);
                    if (stall_left > 0) begin
                        o_trdy = 1'b0;
                        stall_left--;
                    end else if (v.rnd) begin
                        o_trdy = 1'($urandom_range(0, 1));
                    end else begin
                        o_trdy = 1'b1;
                    end
                    if (o_trdy) begin
                        if (exp_q.size() == 0) begin
                            check("token_overrun", ntok + 1, v.exp_count);
                        end else begin
                            e = exp_q.pop_front();
                            check("token_data", o_data, e);
                        end
                        last_data = o_data;
                        ntok++;
                        last_x = cyc;
                        idle   = 0;
                    end else begin
                        stalled = 1;
                        held    = o_data;
                    end
                end else begin
                    o_trdy = 1'b1;
                    idle++;
                end
                prev_irdy = o_irdy;
            end
        end

        if (!seen_done) begin
            check("done_timeout", 0, 1);
            start = 1'b0;
        end
        check("token_count", ntok, v.exp_count);
        check("sent_count_at_done", sent_count, v.exp_count);
        check("scoreboard_empty", exp_q.size(), 0);
`ifndef XMAS_SRC_LFSR_EN
        if (v.exp_count > 0) check("last_token_data", last_data, v.exp_last);
`endif
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("sent_count_hold", sent_count, v.exp_count);
        check("idle_irdy_low", o_irdy, 0);
    endtask

    initial begin
        vecs[0] = '{16'd4, 4'd0,  32'h0000_0010, 0, 1'b0, 4, 32'h0000_0013};
        vecs[1] = '{16'd3, 4'd2,  32'h0000_0100, 0, 1'b0, 3, 32'h0000_0102};
        vecs[2] = '{16'd2, 4'd0,  32'h0000_0010, 5, 1'b0, 2, 32'h0000_0011};
        vecs[3] = '{16'd0, 4'd3,  32'h0000_0055, 0, 1'b0, 0, 32'h0000_0000};
        vecs[4] = '{16'd3, 4'd0,  32'hFFFF_FFFE, 0, 1'b0, 3, 32'h0000_0000};
        vecs[5] = '{16'd5, 4'd1,  32'h0000_2000, 0, 1'b1, 5, 32'h0000_2004};
        vecs[6] = '{16'd1, 4'd15, 32'h0000_0007, 0, 1'b0, 1, 32'h0000_0007};
        vecs[7] = '{16'd8, 4'd0,  32'h0000_0040, 0, 1'b0, 8, 32'h0000_0047};

        rst       = 1'b1;
        start     = 1'b0;
        burst_len = '0;
        gap       = 4'd0;
        base      = '0;
        o_trdy    = 1'b0;
        #12;
        check("reset_irdy", o_irdy, 0);
        check("reset_data", o_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sent_count", sent_count, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        // mid-burst reset after two transfers of an eight-token burst
        @(negedge clk);
        start     = 1'b1;
        burst_len = 16'd8;
        gap       = 4'd0;
        base      = 32'h0000_0040;
        o_trdy    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_sent_count", sent_count, 2);
        check("pre_reset_data", o_data, 32'h0000_0042);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_irdy", o_irdy, 0);
        check("async_reset_data", o_data, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        check("async_reset_sent_count", sent_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
            check("no_resume_after_reset", busy, 0);
        end
        run_burst(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
